uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single PL UART transmitter (the byte stream returned to the PS on the tx GPIO line) among N in-fabric message sources, e.g. button-event reporter, LED status reporter and command echo.
- Sits inside top, between the byte producers and the UART TX serializer.
- Holds a grant for a whole packet, so bytes from different sources never interleave.
- Forces release on over-length packets or stalled sources.

Parameters:
- N, 4, number of requesters (2..8).
- MAX_PKT, 16, maximum bytes per grant; grant is force-released after this many bytes.
- STALL_MAX, 255, consecutive cycles a granted requester may hold req_valid low mid-packet before the grant is revoked.

Ports:
- clk  in  1  system clock (FCLK_CLK0, 100 MHz).
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N  per-requester byte valid.
- req_data  in  8*N  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  in  N  marks the final byte of a packet.
- req_ready  out  N  per-requester byte accepted.
- tx_valid  out  1  byte valid to the UART TX serializer.
- tx_data  out  8  byte to the UART TX serializer.
- tx_ready  in  1  serializer can accept a byte.
- grant  out  N  one-hot current owner; all zero when no owner.
- busy  out  1  high while in XFER.
- trunc  out  1  one-cycle pulse when a grant is released by MAX_PKT.
- abort  out  1  one-cycle pulse when a grant is revoked by STALL_MAX.

Behaviour:
- Reset values:
  - state=IDLE; grant=0; busy=0; trunc=0; abort=0.
  - tx_valid=0; tx_data=0; req_ready=0.
  - Round-robin pointer ptr=N-1, so requester 0 wins first; beat_cnt=0; stall_cnt=0.
- Beat definition: tx_valid & tx_ready in XFER.
- IDLE:
  - grant=0; tx_valid=0; req_ready=0.
  - If any req_valid bit is high, the winner is the first set bit searching ptr+1, ptr+2, ... modulo N.
  - Registered grant=onehot(winner); beat_cnt=0; stall_cnt=0; state goes to XFER next cycle.
  - Latency: req_valid high in cycle t gives grant and tx_valid in cycle t+1.
- XFER (owner g):
  - Combinational path: tx_valid=req_valid[g]; tx_data=req_data[g]; req_ready[g]=tx_ready.
  - Other req_ready bits are 0. Non-owners are ignored regardless of their valid.
  - On each beat, beat_cnt increments.
  - Release to IDLE on a beat with req_last[g]=1. Set ptr=g. No pulse.
  - Release to IDLE on a beat where beat_cnt+1==MAX_PKT and req_last[g]=0. Set ptr=g and pulse trunc in the cycle after that beat.
  - req_valid[g]=0 increments stall_cnt; req_valid[g]=1 clears it. tx_ready low does not count as a stall.
  - When stall_cnt reaches STALL_MAX: go to IDLE, set ptr=g, pulse abort.
  - Last and MAX_PKT on the same beat count as a normal release; trunc stays 0.
- Inter-packet gap: exactly one IDLE cycle after every release, so there is no back-to-back grant.
  - A requester re-requesting immediately wins again only if no other requester is valid.
- Widths: beat_cnt = clog2(MAX_PKT+1) bits; stall_cnt = clog2(STALL_MAX+1) bits; stall_cnt saturates and never wraps.
- req_data/req_last of non-granted requesters are don't-care. tx_data is don't-care when tx_valid=0, but must not be X after reset.
- Asynchronous reset mid-packet:
  - All outputs drop immediately to their reset values and ptr returns to N-1.
  - A partially sent packet is not resumed; the requester must restart it.
- Sources must hold req_valid/req_data stable until req_ready (AXI-stream style). The arbiter does not buffer.

Test Plan:
- Single source: req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_ready=1 -> grant=0001 from cycle t+1; tx_data sequence 41,42,43 on consecutive cycles; IDLE one cycle; ptr=0.
- Fairness: req0..req3 continuously valid, 1-byte packets with last=1 -> grant order 0,1,2,3,0,1; each grant 1 cycle, separated by 1 IDLE cycle; no requester skipped.
- Backpressure: req2 sends 2 bytes while tx_ready toggles 0,1,0,0,1 -> exactly 2 beats; req_ready[2] mirrors tx_ready; stall_cnt stays 0; no abort.
- Truncation: MAX_PKT=16, req1 streams 20 bytes with no last -> release after 16th beat, trunc pulses 1 cycle, next owner is req2 if valid, else req1 again after the IDLE cycle.
- Stall abort: STALL_MAX=8, req3 sends 1 byte (no last) then drops valid -> abort pulses 8 cycles after the drop begins; grant=0; busy=0; then req0 is granted if valid.
- Reset mid-packet: assert reset during req1's 2nd byte -> grant, tx_valid and req_ready go to 0 asynchronously; after release req0 is served first despite req1 also being valid.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte stream.
// A grant is held for a whole packet; over-length or stalled packets are cut.
module uart_tx_arbiter #(
  parameter int N         = 4,
  parameter int MAX_PKT   = 16,
  parameter int STALL_MAX = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_data,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           tx_valid,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic [N-1:0]   grant,
  output logic           busy,
  output logic           trunc,
  output logic           abort
);

  localparam int PW = $clog2(N);
  localparam int BW = $clog2(MAX_PKT + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] own_q, own_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          trunc_q, trunc_d;
  logic          abort_q, abort_d;

  logic          xfer;
  logic          own_valid;
  logic          own_last;
  logic          beat;
  logic [N-1:0]  own_oh;
  logic          win_found;
  logic [PW-1:0] win_idx;
  int            j;

  assign xfer      = (state_q == XFER);
  assign own_valid = req_valid[own_q];
  assign own_last  = req_last[own_q];
  assign own_oh    = N'(1) << own_q;

  // Owner's handshake is passed straight through; nothing is buffered.
  assign tx_valid  = xfer & own_valid;
  assign tx_data   = xfer ? req_data[{own_q, 3'b000} +: 8] : 8'h00;
  assign req_ready = (xfer && tx_ready) ? own_oh : '0;
  assign grant     = xfer ? own_oh : '0;
  assign busy      = xfer;
  assign trunc     = trunc_q;
  assign abort     = abort_q;
  assign beat      = tx_valid & tx_ready;

  // Search ptr+1, ptr+2, ... so the last owner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_q) + k) % N;
      if (!win_found && req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    trunc_d = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = XFER;
          own_d   = win_idx;
          beat_d  = '0;
          stall_d = '0;
        end
      end
      XFER: begin
        if (beat) begin
          beat_d  = beat_q + BW'(1);
          stall_d = '0;
          if (own_last) begin
            state_d = IDLE;
            ptr_d   = own_q;
          end else if (beat_q == BW'(MAX_PKT - 1)) begin
            state_d = IDLE;
            ptr_d   = own_q;
            trunc_d = 1'b1;
          end
        end else if (own_valid) begin
          stall_d = '0;
        end else if (stall_q == SW'(STALL_MAX - 1)) begin
          state_d = IDLE;
          ptr_d   = own_q;
          abort_d = 1'b1;
          stall_d = SW'(STALL_MAX);
        end else if (stall_q != SW'(STALL_MAX)) begin
          stall_d = stall_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      own_q   <= '0;
      ptr_q   <= PW'(N - 1);
      beat_q  <= '0;
      stall_q <= '0;
      trunc_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      trunc_q <= trunc_d;
      abort_q <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets, queued expected
// beats checked by an independent monitor on the falling edge.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MP = 16;
  localparam int SM = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           trunc;
  logic           abort;

  logic       sv [N];
  logic [7:0] sd [N];
  logic       sl [N];

  typedef struct {
    int         src;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_trunc = 0;
  int   n_abort = 0;
  int   run_len = 0;
  logic [N-1:0] prev_grant = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = sv[i];
      req_data[8*i +: 8]   = sd[i];
      req_last[i]          = sl[i];
    end
  end

  uart_tx_arbiter #(.N(N), .MAX_PKT(MP), .STALL_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .trunc(trunc), .abort(abort)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_byte(input int i, input logic [7:0] d, input logic l);
    int cyc;
    sv[i] = 1'b1;
    sd[i] = d;
    sl[i] = l;
    cyc   = 0;
    @(negedge clk);
    while (req_ready[i] !== 1'b1 && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout src=%0d byte=%h: got no ready want ready", i, d);
    end
    @(posedge clk);
    #1;
    sv[i] = 1'b0;
  endtask

  // Monitor: pops one expected beat per accepted byte.
  always @(negedge clk) begin
    exp_t e;
    if (grant != prev_grant && grant != '0) begin
      run_len = 0;
      n_cmp++;
      if (prev_grant != '0) begin
        n_bad++;
        $display("FAIL gap: got grant %b after %b want idle between",
                 grant, prev_grant);
      end
    end
    if (tx_valid && tx_ready) begin
      run_len++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat: got grant=%b data=%h want no beat",
                 grant, tx_data);
      end else begin
        e = exp_q.pop_front();
        if (grant !== (N'(1) << e.src) || tx_data !== e.data) begin
          n_bad++;
          $display("FAIL beat: got grant=%b data=%h want grant=%b data=%h",
                   grant, tx_data, N'(1) << e.src, e.data);
        end
      end
    end
    if (trunc) begin
      n_trunc++;
      chk("trunc_len", run_len, MP);
      chk("trunc_grant", grant, 0);
    end
    if (abort) n_abort++;
    prev_grant = grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      sv[i] = 1'b0;
      sd[i] = 8'h00;
      sl[i] = 1'b0;
    end
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc, 0);
    chk("rst_abort", abort, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single source, three bytes.
    push(0, 8'h41); push(0, 8'h42); push(0, 8'h43);
    fork
      begin
        send_byte(0, 8'h41, 1'b0);
        send_byte(0, 8'h42, 1'b0);
        send_byte(0, 8'h43, 1'b1);
      end
      begin
        @(negedge clk);
        chk("lat_idle", grant, 0);
        @(negedge clk);
        chk("lat_grant", grant, 4'b0001);
        chk("lat_txv", tx_valid, 1);
      end
    join
    @(negedge clk);
    chk("t1_gap_busy", busy, 0);
    chk("t1_gap_grant", grant, 0);
    @(posedge clk);
    #1;

    // Fairness; ptr=0 now so requester 1 leads.
    push(1, 8'h11); push(2, 8'h21); push(3, 8'h31);
    push(0, 8'h01); push(1, 8'h12); push(2, 8'h22);
    fork
      send_byte(0, 8'h01, 1'b1);
      begin send_byte(1, 8'h11, 1'b1); send_byte(1, 8'h12, 1'b1); end
      begin send_byte(2, 8'h21, 1'b1); send_byte(2, 8'h22, 1'b1); end
      send_byte(3, 8'h31, 1'b1);
    join
    chk("fair_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Backpressure on requester 2.
    push(2, 8'hA0); push(2, 8'hA1);
    tx_ready = 1'b0;
    fork
      begin send_byte(2, 8'hA0, 1'b0); send_byte(2, 8'hA1, 1'b1); end
      begin
        logic [4:0] pat;
        pat = 5'b10010;
        @(posedge clk);
        for (int c = 4; c >= 0; c--) begin
          #1;
          tx_ready = pat[c];
          @(negedge clk);
          chk("bp_ready", req_ready[2], tx_ready);
          chk("bp_abort", abort, 0);
          @(posedge clk);
        end
        #1;
        tx_ready = 1'b1;
      end
    join
    chk("bp_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Truncation: req1 20 bytes (last on 20th), req2 waiting.
    for (int b = 0; b < 16; b++) push(1, 8'h80 + 8'(b));
    push(2, 8'hC2);
    for (int b = 16; b < 20; b++) push(1, 8'h80 + 8'(b));
    fork
      for (int b = 0; b < 20; b++) send_byte(1, 8'h80 + 8'(b), b == 19);
      send_byte(2, 8'hC2, 1'b1);
    join
    chk("tr_empty", exp_q.size(), 0);
    chk("tr_count", n_trunc, 1);
    @(posedge clk);
    #1;

    // Stall abort on requester 3.
    push(3, 8'hD3);
    send_byte(3, 8'hD3, 1'b0);
    push(0, 8'h55);
    fork
      begin
        for (int c = 0; c < SM; c++) begin
          @(negedge clk);
          chk("st_busy", busy, 1);
          chk("st_noabort", abort, 0);
        end
        @(negedge clk);
        chk("st_abort", abort, 1);
        chk("st_grant", grant, 0);
        chk("st_busy0", busy, 0);
        @(negedge clk);
        chk("st_next", grant, 4'b0001);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        send_byte(0, 8'h55, 1'b1);
      end
    join
    chk("st_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset mid-packet: req1 owns, second byte pending.
    push(1, 8'h61);
    send_byte(1, 8'h61, 1'b0);
    sv[1]    = 1'b1;
    sd[1]    = 8'h62;
    sl[1]    = 1'b1;
    tx_ready = 1'b0;
    @(negedge clk);
    chk("rs_owned", grant, 4'b0010);
    #2;
    reset = 1'b1;
    #1;
    chk("rs_grant", grant, 0);
    chk("rs_txv", tx_valid, 0);
    chk("rs_ready", req_ready, 0);
    chk("rs_busy", busy, 0);
    sv[0] = 1'b1;
    sd[0] = 8'h70;
    sl[0] = 1'b1;
    sd[1] = 8'h61;
    sl[1] = 1'b0;
    push(0, 8'h70); push(1, 8'h61); push(1, 8'h62);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    tx_ready = 1'b1;
    fork
      send_byte(0, 8'h70, 1'b1);
      begin send_byte(1, 8'h61, 1'b0); send_byte(1, 8'h62, 1'b1); end
    join
    repeat (2) @(negedge clk);
    chk("end_empty", exp_q.size(), 0);
    chk("end_trunc", n_trunc, 1);
    chk("end_abort", n_abort, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
